// File: rtl/cond_logic_reg.sv
// Condition-check and NZCV flag-register stage that follows the ALU.
// Optional performance counters are built when COND_PERF_CNT_EN is defined.
module cond_logic_reg #(
    parameter logic [3:0] FLAG_RST = 4'b0000,
    parameter int         CNT_W    = 32
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             Valid,
    input  logic             Stall,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             PCS,
    input  logic             RegW,
    input  logic             MemW,
    input  logic             NoWrite,
    input  logic             CntClr,
    output logic             CondEx,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic [3:0]       Flags,
    output logic [CNT_W-1:0] ExecCnt,
    output logic [CNT_W-1:0] SquashCnt
);

    logic n_flag, z_flag, c_flag, v_flag;
    logic cond_pass;
    logic flag_we;

    assign {n_flag, z_flag, c_flag, v_flag} = Flags;

    // Conditions test only the registered flags, so an instruction never sees its own result.
    always_comb begin
        cond_pass = 1'b1;
        case (Cond)
            4'b0000: cond_pass = z_flag;
            4'b0001: cond_pass = ~z_flag;
            4'b0010: cond_pass = c_flag;
            4'b0011: cond_pass = ~c_flag;
            4'b0100: cond_pass = n_flag;
            4'b0101: cond_pass = ~n_flag;
            4'b0110: cond_pass = v_flag;
            4'b0111: cond_pass = ~v_flag;
            4'b1000: cond_pass = c_flag & ~z_flag;
            4'b1001: cond_pass = ~c_flag | z_flag;
            4'b1010: cond_pass = (n_flag == v_flag);
            4'b1011: cond_pass = (n_flag != v_flag);
            4'b1100: cond_pass = ~z_flag & (n_flag == v_flag);
            4'b1101: cond_pass = z_flag | (n_flag != v_flag);
            default: cond_pass = 1'b1;
        endcase
    end

    assign CondEx   = Valid & cond_pass;
    assign PCSrc    = PCS & CondEx;
    assign RegWrite = RegW & ~NoWrite & CondEx;
    assign MemWrite = MemW & CondEx;

    assign flag_we = CondEx & ~Stall;

    // gi=0 holds {C,V}, gi=1 holds {N,Z}; each half has its own write enable.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_flag_half
            logic [1:0] half_reg;

            always_ff @(posedge CLK or negedge RESETn) begin
                if (!RESETn) begin
                    half_reg <= FLAG_RST[2*gi +: 2];
                end else if (flag_we && FlagW[gi]) begin
                    half_reg <= ALUFlags[2*gi +: 2];
                end
            end

            assign Flags[2*gi +: 2] = half_reg;
        end
    endgenerate

`ifdef COND_PERF_CNT_EN
    logic [CNT_W-1:0] exec_cnt_reg;
    logic [CNT_W-1:0] squash_cnt_reg;

    // The clear wins over any increment arriving in the same cycle.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            exec_cnt_reg   <= '0;
            squash_cnt_reg <= '0;
        end else if (CntClr) begin
            exec_cnt_reg   <= '0;
            squash_cnt_reg <= '0;
        end else if (!Stall && Valid) begin
            if (CondEx) begin
                exec_cnt_reg <= exec_cnt_reg + CNT_W'(1);
            end else begin
                squash_cnt_reg <= squash_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign ExecCnt   = exec_cnt_reg;
    assign SquashCnt = squash_cnt_reg;
`else
    logic unused_cnt_clr;

    assign unused_cnt_clr = CntClr;
    assign ExecCnt        = '0;
    assign SquashCnt      = '0;
`endif

endmodule

// File: tb/tb_cond_logic_reg.sv
// Self-checking bench for cond_logic_reg: directed steps followed by random traffic
// compared against a behavioural flag/counter model.
module tb_cond_logic_reg;

    logic        CLK = 1'b0;
    logic        RESETn;
    logic        Valid, Stall, PCS, RegW, MemW, NoWrite, CntClr;
    logic [3:0]  Cond, ALUFlags;
    logic [1:0]  FlagW;
    logic        CondEx, PCSrc, RegWrite, MemWrite;
    logic [3:0]  Flags;
    logic [31:0] ExecCnt, SquashCnt;

    int n_chk  = 0;
    int n_fail = 0;

    logic [3:0]  m_flags;
    logic [31:0] m_exec, m_squash;

    always #5 CLK = ~CLK;

    cond_logic_reg dut (
        .CLK(CLK), .RESETn(RESETn), .Valid(Valid), .Stall(Stall),
        .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS(PCS),
        .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite), .CntClr(CntClr),
        .CondEx(CondEx), .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .Flags(Flags), .ExecCnt(ExecCnt), .SquashCnt(SquashCnt)
    );

    // Reference condition table in terms of named flag bits.
    function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: return 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic st, input logic [3:0] c, input logic [3:0] alu,
                         input logic [1:0] fw, input logic pcs, input logic rw, input logic mw,
                         input logic nw, input logic clr);
        logic ce;
        Valid = v; Stall = st; Cond = c; ALUFlags = alu; FlagW = fw;
        PCS = pcs; RegW = rw; MemW = mw; NoWrite = nw; CntClr = clr;
        #1;
        ce = v && ref_pass(c, m_flags);
        check("CondEx",   {31'd0, CondEx},   {31'd0, ce});
        check("PCSrc",    {31'd0, PCSrc},    {31'd0, pcs && ce});
        check("RegWrite", {31'd0, RegWrite}, {31'd0, rw && !nw && ce});
        check("MemWrite", {31'd0, MemWrite}, {31'd0, mw && ce});
    endtask

    task automatic step(input logic v, input logic st, input logic [3:0] c, input logic [3:0] alu,
                        input logic [1:0] fw, input logic pcs, input logic rw, input logic mw,
                        input logic nw, input logic clr);
        logic ce;
        drive(v, st, c, alu, fw, pcs, rw, mw, nw, clr);
        ce = v && ref_pass(c, m_flags);
        @(posedge CLK);
        if (ce && !st) begin
            if (fw[1]) m_flags[3:2] = alu[3:2];
            if (fw[0]) m_flags[1:0] = alu[1:0];
        end
`ifdef COND_PERF_CNT_EN
        if (clr) begin
            m_exec = 0; m_squash = 0;
        end else if (v && !st) begin
            if (ce) m_exec = m_exec + 1;
            else    m_squash = m_squash + 1;
        end
`endif
        #1;
        check("Flags",     {28'd0, Flags}, {28'd0, m_flags});
        check("ExecCnt",   ExecCnt,   m_exec);
        check("SquashCnt", SquashCnt, m_squash);
        $display("step v=%0b st=%0b cond=%h alu=%h fw=%b -> flags=%h exec=%0d squash=%0d",
                 v, st, c, alu, fw, Flags, ExecCnt, SquashCnt);
    endtask

    initial begin
        m_flags = 4'b0000; m_exec = 0; m_squash = 0;
        RESETn = 1'b0;
        Valid = 0; Stall = 0; Cond = 0; ALUFlags = 0; FlagW = 0;
        PCS = 0; RegW = 0; MemW = 0; NoWrite = 0; CntClr = 0;
        #2;
        check("rst_flags",  {28'd0, Flags}, 32'h0);
        check("rst_exec",   ExecCnt, 32'h0);
        check("rst_squash", SquashCnt, 32'h0);
        // EQ against reset flags fails, AL passes
        drive(1, 0, 4'b0000, 4'h0, 2'b00, 0, 1, 0, 0, 0);
        drive(1, 0, 4'b1110, 4'h0, 2'b00, 0, 1, 0, 0, 0);
        @(negedge CLK);
        RESETn = 1'b1;
        @(posedge CLK); #1;

        // SUBS 5-5 sets Z,C; EQ then passes, HI fails
        step(1, 0, 4'b1110, 4'b0110, 2'b11, 0, 1, 0, 0, 0);
        check("flags_0110", {28'd0, Flags}, 32'h6);
        drive(1, 0, 4'b0000, 4'h0, 2'b00, 0, 1, 0, 0, 0);
        check("eq_pass", {31'd0, CondEx}, 32'd1);
        drive(1, 0, 4'b1000, 4'h0, 2'b00, 0, 1, 0, 0, 0);
        check("hi_fail", {31'd0, CondEx}, 32'd0);

        // Split write: only N,Z updated
        step(1, 0, 4'b1110, 4'b1001, 2'b10, 0, 0, 0, 0, 0);
        check("split_1010", {28'd0, Flags}, 32'hA);
        step(1, 0, 4'b1110, 4'b0101, 2'b01, 0, 0, 0, 0, 0);
        check("split_1001", {28'd0, Flags}, 32'h9);

        // Clear flags, then squash with EQ
        step(1, 0, 4'b1110, 4'b0000, 2'b11, 0, 0, 0, 0, 0);
        step(1, 0, 4'b0000, 4'b1111, 2'b11, 1, 1, 1, 0, 0);
        check("squash_flags", {28'd0, Flags}, 32'h0);

        // Stall holds flags; NoWrite suppresses RegWrite only
        step(1, 1, 4'b1110, 4'b1111, 2'b11, 0, 1, 0, 0, 0);
        check("stall_flags", {28'd0, Flags}, 32'h0);
        drive(1, 0, 4'b1110, 4'h0, 2'b00, 0, 1, 0, 1, 0);
        check("nowrite_regw", {31'd0, RegWrite}, 32'd0);
        check("nowrite_ce",   {31'd0, CondEx}, 32'd1);

        // Counters: clear, 3 executed, 2 squashed, 1 bubble
        step(0, 0, 4'b1110, 4'h0, 2'b00, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 0, 4'b1110, 4'h0, 2'b00, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) step(1, 0, 4'b0000, 4'h0, 2'b00, 0, 0, 0, 0, 0);
        step(0, 0, 4'b1110, 4'h0, 2'b00, 0, 0, 0, 0, 0);
`ifdef COND_PERF_CNT_EN
        check("cnt_exec3",   ExecCnt, 32'd3);
        check("cnt_squash2", SquashCnt, 32'd2);
        step(1, 0, 4'b1110, 4'h0, 2'b00, 0, 0, 0, 0, 1);
        check("cnt_clr_exec", ExecCnt, 32'd0);
`else
        check("cnt_tied_exec",   ExecCnt, 32'd0);
        check("cnt_tied_squash", SquashCnt, 32'd0);
`endif

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 7) != 0, $urandom_range(0, 7) == 0,
                 4'($urandom), 4'($urandom), 2'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 $urandom_range(0, 31) == 0);
        end

        // Asynchronous reset asserted mid-cycle while stalled
        step(1, 0, 4'b1110, 4'b1111, 2'b11, 0, 0, 0, 0, 0);
        Stall = 1'b1;
        #2;
        RESETn = 1'b0;
        #1;
        m_flags = 4'b0000; m_exec = 0; m_squash = 0;
        check("async_rst_flags",  {28'd0, Flags}, 32'h0);
        check("async_rst_exec",   ExecCnt, 32'h0);
        check("async_rst_squash", SquashCnt, 32'h0);
        @(negedge CLK);
        RESETn = 1'b1;
        @(posedge CLK); #1;
        step(1, 0, 4'b1110, 4'b1000, 2'b10, 0, 0, 0, 0, 0);
        check("post_rst_flags", {28'd0, Flags}, 32'h8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
